// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, default byte width
// and a constant-foldable clog2 used to size index ports.
package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester after ptr, wrapping at N.
// Kept generic so other shared peripherals can reuse it.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = uart_pkg::clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 transmitter between N_REQ byte producers, sequencing
// the UART send_enable/busy handshake with busy synchronised into the clk domain.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = uart_pkg::DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 4096,
  parameter int GNT_W       = uart_pkg::clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_send_enable,
  output logic [DATA_W-1:0]       tx_send_data,
  input  logic                    tx_busy,
  output logic [GNT_W-1:0]        grant_id,
  output logic                    err_timeout
);

  import uart_pkg::*;

  localparam int CNT_W = clog2(ACK_TIMEOUT + 1);

  tx_state_e               state;
  logic [GNT_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]        timeout_cnt;
  logic [SYNC_STAGES-1:0]  busy_sync;
  logic [SYNC_STAGES-1:0]  sync_fill;
  logic                    busy_s;
  logic                    sync_valid;
  logic [N_REQ-1:0]        arb_gnt;
  logic [GNT_W-1:0]        arb_idx;
  logic                    grant_ok;
  logic                    transfer;
  logic [DATA_W-1:0]       req_bytes [N_REQ];

  // sync_fill marks when busy_s reflects the real tx_busy; the cleared synchroniser would
  // otherwise report "idle" for a few cycles after reset while a frame is still on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_sync <= '0;
      sync_fill <= '0;
    end else begin
      busy_sync <= {busy_sync[SYNC_STAGES-2:0], tx_busy};
      sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign busy_s     = busy_sync[SYNC_STAGES-1];
  assign sync_valid = sync_fill[SYNC_STAGES-1];

  rr_arbiter #(.N(N_REQ), .IDX_W(GNT_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Gated by rst_n so req_ready is also 0 while reset is held.
  assign grant_ok  = rst_n && (state == IDLE) && !busy_s && sync_valid;
  assign req_ready = grant_ok ? arb_gnt : '0;
  assign transfer  = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= GNT_W'(N_REQ - 1);
      grant_id       <= '0;
      tx_send_enable <= 1'b0;
      tx_send_data   <= '0;
      err_timeout    <= 1'b0;
      timeout_cnt    <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            tx_send_data   <= req_bytes[arb_idx];
            rr_ptr         <= arb_idx;
            grant_id       <= arb_idx;
            tx_send_enable <= 1'b1;
            timeout_cnt    <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (busy_s) begin
            tx_send_enable <= 1'b0;
            state          <= WAIT_DONE;
          end else if (timeout_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            // Byte is dropped; rr_ptr already moved so the grant still counts.
            tx_send_enable <= 1'b0;
            err_timeout    <= 1'b1;
            state          <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy_s) state <= IDLE;
        end
        default: begin
          tx_send_enable <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule
